// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions.
// Architectural widths and common datapath types.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/register_file_chk.sv
// Assertion checker for register_file.
// Bound onto the register file from the verification side.
module register_file_chk
  import riscv_pkg::*;
(
  input logic      clk,
  input logic      rst_n,
  input logic      wr_en,
  input reg_addr_t wr_reg,
  input reg_addr_t rd_reg_1,
  input reg_addr_t rd_reg_2,
  input word_t     rd_data_1,
  input word_t     rd_data_2
);

  a_x0_rd1 : assert property (
    @(posedge clk) rd_reg_1 == '0 |-> rd_data_1 == '0
  );

  a_x0_rd2 : assert property (
    @(posedge clk) rd_reg_2 == '0 |-> rd_data_2 == '0
  );

  // A write to x0 must leave every read port unchanged next cycle.
  a_x0_wr1 : assert property (
    @(posedge clk) disable iff (!rst_n)
    (wr_en && wr_reg == '0) |=>
      (!$stable(rd_reg_1) || $stable(rd_data_1))
  );

  a_x0_wr2 : assert property (
    @(posedge clk) disable iff (!rst_n)
    (wr_en && wr_reg == '0) |=>
      (!$stable(rd_reg_2) || $stable(rd_data_2))
  );

endmodule

// File: rtl/register_file.sv
// RISC-V integer register file: 2 async read, 1 sync write.
// x0 has no storage and always reads as zero.
module register_file
  import riscv_pkg::*;
#(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int NUM_REGS = riscv_pkg::NUM_REGS,
  parameter int ADDR_W   = riscv_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_reg,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [ADDR_W-1:0] rd_reg_1,
  input  logic [ADDR_W-1:0] rd_reg_2,
  output logic [XLEN-1:0]   rd_data_1,
  output logic [XLEN-1:0]   rd_data_2
);

  word_t regs_q [1:NUM_REGS-1];
  logic  wr_ok;

  assign wr_ok = wr_en && (wr_reg != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[wr_reg] <= wr_data;
    end
  end

  // No bypass: forwarding belongs to the pipeline.
  assign rd_data_1 = (rd_reg_1 == '0) ? '0 : regs_q[rd_reg_1];
  assign rd_data_2 = (rd_reg_2 == '0) ? '0 : regs_q[rd_reg_2];

endmodule

// File: tb/tb_register_file.sv
// Directed and random checks for register_file.
// Drives 2 units after posedge, samples 2 units before the next.
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [4:0]  rd_reg_1;
  logic [4:0]  rd_reg_2;
  logic [31:0] rd_data_1;
  logic [31:0] rd_data_2;

  int n_checks;
  int n_errors;

  logic [31:0] mdl [32];
  logic [31:0] cov1;
  logic [31:0] cov2;

  register_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .rd_reg_1  (rd_reg_1),
    .rd_reg_2  (rd_reg_2),
    .rd_data_1 (rd_data_1),
    .rd_data_2 (rd_data_2)
  );

  bind register_file register_file_chk u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .rd_reg_1  (rd_reg_1),
    .rd_reg_2  (rd_reg_2),
    .rd_data_1 (rd_data_1),
    .rd_data_2 (rd_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(
    input logic        en,
    input logic [4:0]  wr,
    input logic [31:0] wd,
    input logic [4:0]  r1,
    input logic [4:0]  r2
  );
    @(posedge clk);
    #2;
    wr_en    = en;
    wr_reg   = wr;
    wr_data  = wd;
    rd_reg_1 = r1;
    rd_reg_2 = r2;
    #6;
    check("rd1", rd_data_1, mdl[r1]);
    check("rd2", rd_data_2, mdl[r2]);
    if (en && wr != 5'd0) mdl[wr] = wd;
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_reg_1 = 5'(i);
      rd_reg_2 = 5'(31 - i);
      #1;
      check(tag, rd_data_1, 32'h0);
      check(tag, rd_data_2, 32'h0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cov1     = '0;
    cov2     = '0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    rst_n    = 1'b1;
    wr_en    = 1'b0;
    wr_reg   = '0;
    wr_data  = '0;
    rd_reg_1 = '0;
    rd_reg_2 = '0;
    #1 rst_n = 1'b0;
    sweep_zero("rst0");
    @(posedge clk);
    #2 rst_n = 1'b1;

    cyc(1'b1, 5'd1, 32'h12345678, 5'd0, 5'd0);
    cyc(1'b1, 5'd31, 32'hCAFEF00D, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    check("x1", rd_data_1, 32'h12345678);
    check("x31", rd_data_2, 32'hCAFEF00D);

    cyc(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    check("x0_p1", rd_data_1, 32'h0);
    check("x0_p2", rd_data_2, 32'h0);

    cyc(1'b0, 5'd7, 32'hAAAA5555, 5'd7, 5'd7);
    cyc(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    check("wen0_x7", rd_data_1, 32'h0);

    cyc(1'b1, 5'd3, 32'h1, 5'd0, 5'd0);
    cyc(1'b1, 5'd3, 32'h2, 5'd3, 5'd3);
    check("rdw_old1", rd_data_1, 32'h1);
    check("rdw_old2", rd_data_2, 32'h1);
    cyc(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    check("rdw_new1", rd_data_1, 32'h2);
    check("rdw_new2", rd_data_2, 32'h2);

    for (int n = 0; n < 10000; n++) begin
      logic [4:0] w;
      logic [4:0] a;
      logic [4:0] b;
      w = 5'($urandom_range(0, 31));
      a = 5'($urandom_range(0, 31));
      b = 5'($urandom_range(0, 31));
      cov1[a] = 1'b1;
      cov2[b] = 1'b1;
      cyc(1'($urandom_range(0, 1)), w, $urandom, a, b);
    end
    check("cov_p1", cov1, 32'hFFFFFFFF);
    check("cov_p2", cov2, 32'hFFFFFFFF);

    cyc(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    check("x5_pre", rd_data_1, 32'hDEADBEEF);
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    wr_en   = 1'b1;
    wr_reg  = 5'd5;
    wr_data = 32'h13572468;
    sweep_zero("rst_mid");
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    wr_en = 1'b0;
    cyc(1'b1, 5'd9, 32'h0BADF00D, 5'd5, 5'd5);
    cyc(1'b0, 5'd0, 32'h0, 5'd9, 5'd5);
    check("x9_post", rd_data_1, 32'h0BADF00D);
    check("x5_post", rd_data_2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
